// File: rtl/piso_frame_tx_pkg.sv
// +-------------------------------------------------------------------+
// | piso_frame_tx_pkg : shared FSM encoding and line-level constants  |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
`default_nettype none

package piso_frame_tx_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   localparam logic c_IDLE_LEVEL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/piso_frame_tx_bit_timer.sv
// +-------------------------------------------------------------------+
// | bit_timer : one-cycle tick every DIV cycles, restarts on load     |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
`default_nettype none

module bit_timer #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_en,
   output logic o_tick
);

   localparam int               CNT_W  = $clog2(DIV + 1);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_load) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= (r_cnt == c_LAST) ? '0 : r_cnt + CNT_W'(1);
      end
   end

   assign o_tick = i_en && !i_load && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/piso_frame_tx.sv
// +-------------------------------------------------------------------+
// | piso_frame_tx : parallel-in serial-out framer (start/data/par/stop)|
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
`default_nettype none

module piso_frame_tx
   import piso_frame_tx_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DIV       = 4,
   parameter int PARITY_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              serial_out,
   output logic              busy,
   output logic              tx_done
);

   localparam int                IDX_W      = $clog2(DATA_W + 1);
   localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(DATA_W - 1);

   state_t              r_state;
   logic [DATA_W-1:0]   r_shift;
   logic [IDX_W-1:0]    r_idx;
   logic                r_par;
   logic                r_ser;
   logic                r_done;
   logic                w_tick;

   // Timer is held cleared in IDLE so the start bit gets a full period.
   bit_timer #(.DIV(DIV)) u_bit_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (r_state == S_IDLE),
      .i_en   (r_state != S_IDLE),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_idx   <= '0;
         r_par   <= 1'b0;
         r_ser   <= c_IDLE_LEVEL;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_shift <= in_data;
                  r_par   <= ^in_data;
                  r_idx   <= '0;
                  r_ser   <= ~c_IDLE_LEVEL;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_tick) begin
                  r_ser   <= r_shift[0];
                  r_shift <= r_shift >> 1;
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  if (r_idx == c_LAST_IDX) begin
                     r_idx <= '0;
                     if (PARITY_EN != 0) begin
                        r_ser   <= r_par;
                        r_state <= S_PARITY;
                     end else begin
                        r_ser   <= 1'b1;
                        r_state <= S_STOP;
                     end
                  end else begin
                     r_idx   <= r_idx + IDX_W'(1);
                     r_ser   <= r_shift[0];
                     r_shift <= r_shift >> 1;
                  end
               end
            end
            S_PARITY: begin
               if (w_tick) begin
                  r_ser   <= 1'b1;
                  r_state <= S_STOP;
               end
            end
            S_STOP: begin
               if (w_tick) begin
                  r_ser   <= c_IDLE_LEVEL;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_ser   <= c_IDLE_LEVEL;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = (r_state == S_IDLE);
   assign busy       = (r_state != S_IDLE);
   assign serial_out = r_ser;
   assign tx_done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_piso_frame_tx.sv
// +-------------------------------------------------------------------+
// | tb_piso_frame_tx : directed bench over three parameterisations    |
// | Revision 1.0                                                      |
// +-------------------------------------------------------------------+
`default_nettype none

module tb_piso_frame_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] d   = 8'h00;
   logic       v_a = 1'b0;
   logic       v_b = 1'b0;
   logic       v_c = 1'b0;
   logic [1:0] sel = 2'd0;

   logic a_rdy, a_ser, a_busy, a_done;
   logic b_rdy, b_ser, b_busy, b_done;
   logic c_rdy, c_ser, c_busy, c_done;
   logic w_rdy, w_ser, w_busy, w_done;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   piso_frame_tx #(.DATA_W(8), .DIV(4), .PARITY_EN(1)) dut_a (
      .clk(clk), .rst(rst), .in_data(d), .in_valid(v_a), .in_ready(a_rdy),
      .serial_out(a_ser), .busy(a_busy), .tx_done(a_done));

   piso_frame_tx #(.DATA_W(8), .DIV(1), .PARITY_EN(1)) dut_b (
      .clk(clk), .rst(rst), .in_data(d), .in_valid(v_b), .in_ready(b_rdy),
      .serial_out(b_ser), .busy(b_busy), .tx_done(b_done));

   piso_frame_tx #(.DATA_W(8), .DIV(2), .PARITY_EN(0)) dut_c (
      .clk(clk), .rst(rst), .in_data(d), .in_valid(v_c), .in_ready(c_rdy),
      .serial_out(c_ser), .busy(c_busy), .tx_done(c_done));

   assign w_ser  = (sel == 2'd0) ? a_ser  : (sel == 2'd1) ? b_ser  : c_ser;
   assign w_busy = (sel == 2'd0) ? a_busy : (sel == 2'd1) ? b_busy : c_busy;
   assign w_done = (sel == 2'd0) ? a_done : (sel == 2'd1) ? b_done : c_done;
   assign w_rdy  = (sel == 2'd0) ? a_rdy  : (sel == 2'd1) ? b_rdy  : c_rdy;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic idle_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk("idle.serial", 32'(w_ser),  32'd1);
         chk("idle.busy",   32'(w_busy), 32'd0);
         chk("idle.done",   32'(w_done), 32'd0);
         chk("idle.ready",  32'(w_rdy),  32'd1);
      end
   endtask

   // Caller raises valid at a negedge; bits[0] is the start bit, sent first.
   task automatic check_frame(input logic [31:0] bits, input int nbits, input int div,
                              input bit keep, input logic [7:0] nd, input bit poke);
      for (int i = 0; i < nbits; i++) begin
         for (int j = 0; j < div; j++) begin
            @(negedge clk);
            chk("frame.serial", 32'(w_ser),  32'(bits[i]));
            chk("frame.busy",   32'(w_busy), 32'd1);
            chk("frame.done",   32'(w_done), 32'd0);
            chk("frame.ready",  32'(w_rdy),  32'd0);
            if (i == 0 && j == 0) begin
               if (!keep) begin
                  v_a = 1'b0;
                  v_b = 1'b0;
                  v_c = 1'b0;
               end
               d = nd;
            end
            if (poke && i == 3 && j == 0) v_c = 1'b1;
            if (poke && i == 3 && j == 1) v_c = 1'b0;
         end
      end
      @(negedge clk);
      chk("end.done",   32'(w_done), 32'd1);
      chk("end.serial", 32'(w_ser),  32'd1);
      chk("end.ready",  32'(w_rdy),  32'd1);
      chk("end.busy",   32'(w_busy), 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         #1;
         chk("reset.serial", 32'(w_ser),  32'd1);
         chk("reset.busy",   32'(w_busy), 32'd0);
         chk("reset.done",   32'(w_done), 32'd0);
         chk("reset.ready",  32'(w_rdy),  32'd1);
      end
      @(negedge clk);
      rst = 1'b0;
      sel = 2'd0;
      idle_cycles(2);

      // 0xA5, DIV=4, parity 0; data bus zeroed mid-frame
      d = 8'hA5; v_a = 1'b1;
      check_frame({21'd0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 4, 1'b0, 8'h00, 1'b0);
      idle_cycles(2);

      // 0x5A with the bus cleared after acceptance
      d = 8'h5A; v_a = 1'b1;
      check_frame({21'd0, 1'b1, 1'b0, 8'h5A, 1'b0}, 11, 4, 1'b0, 8'h00, 1'b0);
      idle_cycles(1);

      // DIV=1, 0x01, parity 1
      sel = 2'd1;
      d = 8'h01; v_b = 1'b1;
      check_frame({21'd0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, 1, 1'b0, 8'h00, 1'b0);
      idle_cycles(2);

      // back-to-back 0x3C then 0xC3 with valid held
      sel = 2'd0;
      d = 8'h3C; v_a = 1'b1;
      check_frame({21'd0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, 4, 1'b1, 8'hC3, 1'b0);
      check_frame({21'd0, 1'b1, 1'b0, 8'hC3, 1'b0}, 11, 4, 1'b0, 8'h00, 1'b0);
      idle_cycles(2);

      // no parity, DIV=2, 0x80, stray valid pulse while busy
      sel = 2'd2;
      d = 8'h80; v_c = 1'b1;
      check_frame({22'd0, 1'b1, 8'h80, 1'b0}, 10, 2, 1'b0, 8'h77, 1'b1);
      idle_cycles(3);

      // reset during third data bit of 0xFF, word offered in reset cycle
      sel = 2'd0;
      d = 8'hFF; v_a = 1'b1;
      @(negedge clk);
      v_a = 1'b0;
      repeat (12) @(negedge clk);
      chk("mid.serial", 32'(w_ser),  32'd1);
      chk("mid.busy",   32'(w_busy), 32'd1);
      rst = 1'b1; v_a = 1'b1; d = 8'h55;
      @(negedge clk);
      chk("abort.serial", 32'(w_ser),  32'd1);
      chk("abort.busy",   32'(w_busy), 32'd0);
      chk("abort.done",   32'(w_done), 32'd0);
      chk("abort.ready",  32'(w_rdy),  32'd1);
      rst = 1'b0; v_a = 1'b0;
      idle_cycles(6);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/piso_frame_tx.md
PISO_FRAME_TX -- requirements
Module: piso_frame_tx

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning payload bits per frame (legal 1..32).
REQ-002 The module SHALL have parameter DIV, default 4, meaning clock cycles per serial bit (legal >= 1).
REQ-003 The module SHALL have parameter PARITY_EN, default 1, meaning 1 inserts an even-parity bit and 0 omits it.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port in_data, input, DATA_W bits: parallel word to transmit.
REQ-007 The module SHALL have port in_valid, input, 1 bit: in_data is offered.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-009 The module SHALL have port serial_out, output, 1 bit: registered serial line, idle high.
REQ-010 The module SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-011 The module SHALL have port tx_done, output, 1 bit: single-cycle pulse at frame completion.

Function
REQ-012 A word SHALL be accepted on a rising edge where in_valid && in_ready; in_data is captured into an internal shift register on that edge.
REQ-013 in_ready SHALL be high only in IDLE; in_valid with in_ready low SHALL have no effect, and in_valid dropped before acceptance SHALL start nothing.
REQ-014 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 Transitions: IDLE->START on accept; START->DATA after DIV cycles; DATA->PARITY (PARITY_EN=1) or DATA->STOP (PARITY_EN=0) after DATA_W bits; PARITY->STOP after DIV cycles; STOP->IDLE after DIV cycles.
REQ-016 serial_out SHALL be 1 in IDLE, 0 in START, payload bits LSB-first in DATA, even parity (XOR of the captured word) in PARITY, and 1 in STOP.
REQ-017 Each bit SHALL be held for exactly DIV clock cycles; the first start-bit cycle SHALL be the cycle after the accept edge.
REQ-018 Frame length SHALL be (DATA_W + PARITY_EN + 2) * DIV cycles, with no gaps between bits.
REQ-019 Changes on in_data after acceptance SHALL NOT affect the frame in flight.
REQ-020 tx_done SHALL be high for exactly one cycle, namely the first cycle after the last stop-bit cycle; in_ready SHALL be high in that same cycle.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 With in_valid held high continuously, consecutive frames SHALL be separated by exactly one idle-high cycle (the acceptance cycle).
REQ-023 The bit-timer counter SHALL be ceil(log2(DIV+1)) bits wide; the bit-index counter SHALL be ceil(log2(DATA_W+1)) bits wide; neither SHALL wrap within a frame.
REQ-024 DIV=1 SHALL yield one bit per cycle with no idle cycles inside the frame.

Reset
REQ-025 On a rising edge with rst=1, the block SHALL enter IDLE; serial_out=1, busy=0, tx_done=0, in_ready=1 from the next cycle; counters and the shift register clear to 0.
REQ-026 A reset asserted mid-frame SHALL abort the frame and discard the word, with serial_out high on the next cycle; a word offered in the reset cycle SHALL NOT be accepted.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding (IDLE..STOP) and the idle-line level constant.
REQ-028 The bit-period timer SHALL be one sub-module, bit_timer, which emits a one-cycle tick every DIV cycles while enabled and restarts on load.

Verification (DATA_W=8)
REQ-029 DIV=4, PARITY_EN=1, send 0xA5 -> serial_out = 0 | 1,0,1,0,0,1,0,1 | 0 | 1, each held 4 cycles, 44 cycles total; tx_done one cycle after.
REQ-030 DIV=1, PARITY_EN=1, send 0x01 -> 0,1,0,0,0,0,0,0,0,1,1 over 11 cycles (parity=1).
REQ-031 in_valid held high with 0x3C then 0xC3 -> two back-to-back frames with exactly one idle-high cycle between them; second frame data 1,1,0,0,0,0,1,1.
REQ-032 rst pulsed in the 3rd DATA bit of 0xFF -> serial_out=1, busy=0 next cycle; no tx_done; in_ready=1.
REQ-033 in_data changed to 0x00 during the frame of 0x5A -> transmitted bits still 0,1,0,1,1,0,1,0.
REQ-034 PARITY_EN=0, DIV=2, send 0x80 -> 10 bits (20 cycles), no parity bit; in_valid pulses while busy are ignored.
